dds_sweep: RTL and testbench
============================

Name: dds_sweep

Overview:
- Upstream sequencer for the `dds` SPI front end.
- Generates a linear frequency sweep.
- Emits each 28-bit tuning word as four byte writes on the `dds` write-port interface (`port_id`/`out_port`/`write_strobe`), the same interface the PicoBlaze drives.
- Sits beside the PicoBlaze; its bus outputs are ORed/muxed into `dds` when the sweep owns the bus.

Parameters:
- PORT_BASE, 8'h10, port_id of tuning-word byte 0; bytes 1..3 use PORT_BASE+1..+3. A write to PORT_BASE+3 commits the word and launches the `dds` serial transfer.
- MIN_DWELL, 80, minimum cycles from one commit strobe to the next point's first strobe. Covers the `dds` serial frame; must be ≥8.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse; begin sweep (honoured only when idle)
- abort  in  1  one-cycle pulse; stop sweep
- f_start  in  28  first tuning word
- f_step  in  28  increment per point (two's-complement wrap mod 2^28)
- n_points  in  16  number of points; 0 treated as 1
- dwell  in  16  cycles per point; values below MIN_DWELL clamped to MIN_DWELL
- port_id  out  8  write address to dds
- out_port  out  8  write data to dds
- write_strobe  out  1  one-cycle write qualifier
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at normal completion
- f_cur  out  28  word most recently committed

Behaviour:
- Reset: state IDLE; port_id=0, out_port=0, write_strobe=0, busy=0, done=0, f_cur=0. Reset mid-write or mid-dwell abandons immediately; a partial word is acceptable only under reset.
- States:
  - IDLE: start=1 → latch f_start, f_step, n_points (0→1), dwell_eff=max(dwell,MIN_DWELL) into internal regs; freq=f_start; busy=1 next cycle; go to WR.
  - WR: 4 byte writes, one every 2 cycles (strobe cycle, then gap cycle); strobes at entry+0, +2, +4, +6.
    - byte0: port PORT_BASE, data freq[7:0]
    - byte1: port +1, data freq[15:8]
    - byte2: port +2, data freq[23:16]
    - byte3: port +3, data {4'b0,freq[27:24]}
    - f_cur updated to freq on the byte3 strobe cycle.
  - DWELL: counter loaded on the byte3 strobe. The next point's byte0 strobe occurs exactly dwell_eff cycles after byte3's strobe.
  - NEXT: if points_left==1, go to IDLE with done=1 for one cycle and busy=0 in that same cycle. Otherwise freq=freq+f_step (28-bit wrap, no saturation), points_left−1, go to WR.
- Latency: start at cycle T → first strobe at T+2.
- Bus hold: port_id/out_port hold their last values between strobes. write_strobe is never high on two consecutive cycles.
- abort:
  - in DWELL: go to IDLE next cycle, busy=0, done not pulsed.
  - in WR: finish the current 4-byte group (`dds` never receives a torn word), then IDLE, no done.
  - in IDLE: no effect.
- start while busy: ignored; latched parameters unchanged.
- start and abort in the same cycle in IDLE: start wins. Abort only acts on an active sweep.
- Inputs f_start/f_step/n_points/dwell may change freely while busy; only the values latched at start are used.
- points_left: 16-bit; n_points=16'hFFFF gives 65535 points.

Test Plan:
- rst, f_start=28'h0123456, f_step=1, n_points=1, dwell=0, start@T:
  - strobes at T+2/+4/+6/+8 with (10,56),(11,34),(12,12),(13,00)
  - f_cur=0123456 at T+8
  - done=1 at T+8+80, busy low same cycle
- f_start=28'hFFFFFFE, f_step=2, n_points=3, dwell=100:
  - committed words FFFFFFE, 0000000, 0000002 (wrap)
  - commit-to-commit spacing 100 cycles
  - exactly 12 strobes, one done
- n_points=0:
  - behaves as 1 point: 4 strobes, done once
- abort asserted on cycle of byte1 strobe of point 2:
  - bytes 2,3 of point 2 still issued
  - busy=0 two cycles after byte3
  - no done; point 3 never written
- start pulsed mid-sweep with different f_start:
  - sweep unaffected, output sequence identical to an undisturbed run
- rst asserted during DWELL:
  - next cycle all outputs 0, state IDLE
  - a new start then produces a clean sweep from the new f_start

Source files
------------

// File: rtl/dds_sweep.sv
// Linear frequency-sweep sequencer for the dds SPI front end: each point's
// 28-bit tuning word is written as four byte strobes on the PicoBlaze-style port bus.
module dds_sweep #(
  parameter logic [7:0] PORT_BASE = 8'h10,
  parameter int         MIN_DWELL = 80
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [27:0] f_start,
  input  logic [27:0] f_step,
  input  logic [15:0] n_points,
  input  logic [15:0] dwell,
  output logic [7:0]  port_id,
  output logic [7:0]  out_port,
  output logic        write_strobe,
  output logic        busy,
  output logic        done,
  output logic [27:0] f_cur
);

  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_WR    = 2'd1;
  localparam logic [1:0]  ST_DWELL = 2'd2;
  localparam logic [15:0] MIN_DWELL_W = 16'(MIN_DWELL);

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [27:0] freq_q, freq_d;
  logic [27:0] step_q, step_d;
  logic [15:0] points_left_q, points_left_d;
  logic [15:0] dwell_eff_q, dwell_eff_d;
  logic [15:0] dwell_cnt_q, dwell_cnt_d;
  logic        abort_pend_q, abort_pend_d;
  logic [7:0]  port_id_q, port_id_d;
  logic [7:0]  out_port_q, out_port_d;
  logic        write_strobe_q, write_strobe_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [27:0] f_cur_q, f_cur_d;
  logic [27:0] next_freq;

  function automatic logic [7:0] word_byte(input logic [27:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      2'd3:    b = {4'b0000, w[27:24]};
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign next_freq = freq_q + step_q;

  // Sweep sequencing: even WR phases emit a byte, phase 6 commits the word.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    freq_d         = freq_q;
    step_d         = step_q;
    points_left_d  = points_left_q;
    dwell_eff_d    = dwell_eff_q;
    dwell_cnt_d    = dwell_cnt_q;
    abort_pend_d   = abort_pend_q;
    port_id_d      = port_id_q;
    out_port_d     = out_port_q;
    write_strobe_d = 1'b0;
    busy_d         = busy_q;
    done_d         = 1'b0;
    f_cur_d        = f_cur_q;
    case (state_q)
      ST_IDLE: begin
        abort_pend_d = 1'b0;
        if (start) begin
          freq_d        = f_start;
          step_d        = f_step;
          points_left_d = (n_points == 16'd0) ? 16'd1 : n_points;
          dwell_eff_d   = (dwell < MIN_DWELL_W) ? MIN_DWELL_W : dwell;
          cnt_d         = 3'd0;
          busy_d        = 1'b1;
          state_d       = ST_WR;
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_WR: begin
        if (abort) begin
          abort_pend_d = 1'b1;
        end else begin
          abort_pend_d = abort_pend_q;
        end
        if (cnt_q[0] == 1'b0) begin
          write_strobe_d = 1'b1;
          port_id_d      = PORT_BASE + {6'b000000, cnt_q[2:1]};
          out_port_d     = word_byte(freq_q, cnt_q[2:1]);
        end else begin
          write_strobe_d = 1'b0;
        end
        if (cnt_q == 3'd6) begin
          f_cur_d = freq_q;
          // An aborted group spends one extra gap cycle before leaving.
          if (abort || abort_pend_q) begin
            cnt_d = 3'd7;
          end else begin
            state_d     = ST_DWELL;
            dwell_cnt_d = dwell_eff_q - 16'd1;
          end
        end else if (cnt_q == 3'd7) begin
          state_d = ST_DWELL;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_DWELL: begin
        if (abort || abort_pend_q) begin
          state_d      = ST_IDLE;
          busy_d       = 1'b0;
          abort_pend_d = 1'b0;
        end else if (dwell_cnt_q != 16'd0) begin
          dwell_cnt_d = dwell_cnt_q - 16'd1;
        end else if (points_left_q == 16'd1) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          // Last dwell cycle doubles as the next point's byte0 issue cycle.
          freq_d         = next_freq;
          points_left_d  = points_left_q - 16'd1;
          write_strobe_d = 1'b1;
          port_id_d      = PORT_BASE;
          out_port_d     = word_byte(next_freq, 2'd0);
          cnt_d          = 3'd1;
          state_d        = ST_WR;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        busy_d       = 1'b0;
        abort_pend_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= 3'd0;
      freq_q         <= 28'd0;
      step_q         <= 28'd0;
      points_left_q  <= 16'd0;
      dwell_eff_q    <= 16'd0;
      dwell_cnt_q    <= 16'd0;
      abort_pend_q   <= 1'b0;
      port_id_q      <= 8'd0;
      out_port_q     <= 8'd0;
      write_strobe_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      f_cur_q        <= 28'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      freq_q         <= freq_d;
      step_q         <= step_d;
      points_left_q  <= points_left_d;
      dwell_eff_q    <= dwell_eff_d;
      dwell_cnt_q    <= dwell_cnt_d;
      abort_pend_q   <= abort_pend_d;
      port_id_q      <= port_id_d;
      out_port_q     <= out_port_d;
      write_strobe_q <= write_strobe_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      f_cur_q        <= f_cur_d;
    end
  end

  assign port_id      = port_id_q;
  assign out_port     = out_port_q;
  assign write_strobe = write_strobe_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign f_cur        = f_cur_q;

endmodule

// File: tb/tb_dds_sweep.sv
// Self-checking bench for dds_sweep: a table of sweep cases plus random sweeps,
// each checked cycle by cycle against a timeline computed from the sweep rules.
module tb_dds_sweep;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [27:0] f_start, f_step;
  logic [15:0] n_points, dwell;
  logic [7:0]  port_id, out_port;
  logic        write_strobe, busy, done;
  logic [27:0] f_cur;

  int total = 0;
  int bad   = 0;

  dds_sweep dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .f_start(f_start), .f_step(f_step), .n_points(n_points), .dwell(dwell),
    .port_id(port_id), .out_port(out_port), .write_strobe(write_strobe),
    .busy(busy), .done(done), .f_cur(f_cur)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [7:0]  port;
    logic [7:0]  data;
    logic [27:0] word;
  } ev_t;

  typedef struct {
    logic [27:0] fs;
    logic [27:0] st;
    logic [15:0] np;
    logic [15:0] dw;
    int          abort_off;
    int          mid_off;
    int          exp_strobes;
    int          exp_done;
    logic [27:0] exp_fcur;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Runs one sweep from idle (called just after a falling edge); offsets are cycles after start.
  task automatic run_sweep(input logic [27:0] fs, input logic [27:0] st, input logic [15:0] np,
                           input logic [15:0] dw, input int abort_off, input int mid_off,
                           output int n_strobes, output int n_done);
    ev_t  q[$];
    ev_t  e;
    int   npe, d, per, last_p, busy_end, done_cyc, rel, p, rel2;
    logic prev_strobe;
    logic [27:0] w;
    npe      = (np == 16'd0) ? 1 : int'(np);
    d        = (dw < 16'd80) ? 80 : int'(dw);
    per      = 6 + d;
    last_p   = npe - 1;
    done_cyc = 2 + last_p * per + 6 + d;
    busy_end = done_cyc;
    if (abort_off >= 1 && abort_off < done_cyc) begin
      rel  = abort_off - 2;
      p    = (rel < 0) ? 0 : rel / per;
      rel2 = rel - p * per;
      last_p   = p;
      done_cyc = -1;
      busy_end = (rel2 <= 5) ? (2 + p * per + 8) : (abort_off + 1);
    end
    for (int pp = 0; pp <= last_p; pp++) begin
      w = 28'(longint'(fs) + longint'(st) * longint'(pp));
      for (int i = 0; i < 4; i++) begin
        e.cyc  = 2 + pp * per + 2 * i;
        e.port = 8'h10 + 8'(i);
        e.data = 8'((w >> (8 * i)) & 28'hFF);
        e.word = w;
        q.push_back(e);
      end
    end
    n_strobes   = 0;
    n_done      = 0;
    prev_strobe = 1'b0;
    f_start = fs; f_step = st; n_points = np; dwell = dw;
    start = 1'b1;
    abort = (abort_off == 0);
    for (int k = 1; k <= busy_end + 4; k++) begin
      @(negedge clk);
      if (write_strobe) begin
        n_strobes++;
        chk("strobe_gap", {31'd0, prev_strobe}, 32'd0);
        if (q.size() == 0) begin
          chk("extra_strobe", 32'(k), 32'hFFFFFFFF);
        end else begin
          e = q.pop_front();
          chk("strobe_cycle", 32'(k), 32'(e.cyc));
          chk("port_id", {24'd0, port_id}, {24'd0, e.port});
          chk("out_port", {24'd0, out_port}, {24'd0, e.data});
          if (e.port == 8'h13) chk("f_cur_commit", {4'd0, f_cur}, {4'd0, e.word});
        end
      end
      prev_strobe = write_strobe;
      if (done) n_done++;
      chk("busy", {31'd0, busy}, {31'd0, k < busy_end});
      chk("done", {31'd0, done}, {31'd0, k == done_cyc});
      start    = (k == mid_off);
      abort    = (k == abort_off);
      f_start  = 28'($urandom);
      f_step   = 28'($urandom);
      n_points = 16'($urandom);
      dwell    = 16'($urandom);
    end
    chk("missing_strobes", 32'(q.size()), 32'd0);
    start = 1'b0;
    abort = 1'b0;
  endtask

  vec_t vecs[8];
  int   ns, nd;

  initial begin
    vecs[0] = '{28'h0123456, 28'h0000001, 16'd1, 16'd0,   -1, -1, 4,  1, 28'h0123456};
    vecs[1] = '{28'hFFFFFFE, 28'h0000002, 16'd3, 16'd100, -1, -1, 12, 1, 28'h0000002};
    vecs[2] = '{28'h0ABCDEF, 28'h0000005, 16'd0, 16'd50,  -1, -1, 4,  1, 28'h0ABCDEF};
    vecs[3] = '{28'h1000000, 28'h0000100, 16'd3, 16'd80,  90, -1, 8,  0, 28'h1000100};
    vecs[4] = '{28'h0000010, 28'hFFFFFFF, 16'd2, 16'd85,  -1, 30, 8,  1, 28'h000000F};
    vecs[5] = '{28'h0555555, 28'h0000010, 16'd4, 16'd90,  28, -1, 4,  0, 28'h0555555};
    vecs[6] = '{28'h0000ABC, 28'h0000001, 16'd2, 16'd79,  -1, -1, 8,  1, 28'h0000ABD};
    vecs[7] = '{28'h0777777, 28'h0000003, 16'd1, 16'd0,   0,  -1, 4,  1, 28'h0777777};

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    f_start = 28'h0; f_step = 28'h0; n_points = 16'h0; dwell = 16'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_port_id", {24'd0, port_id}, 32'd0);
    chk("rst_out_port", {24'd0, out_port}, 32'd0);
    chk("rst_strobe", {31'd0, write_strobe}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_f_cur", {4'd0, f_cur}, 32'd0);

    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("idle_abort_busy", {31'd0, busy}, 32'd0);
      chk("idle_abort_strobe", {31'd0, write_strobe}, 32'd0);
      @(negedge clk);
    end

    for (int v = 0; v < 8; v++) begin
      run_sweep(vecs[v].fs, vecs[v].st, vecs[v].np, vecs[v].dw,
                vecs[v].abort_off, vecs[v].mid_off, ns, nd);
      chk($sformatf("vec%0d_strobes", v), 32'(ns), 32'(vecs[v].exp_strobes));
      chk($sformatf("vec%0d_done", v), 32'(nd), 32'(vecs[v].exp_done));
      chk($sformatf("vec%0d_f_cur", v), {4'd0, f_cur}, {4'd0, vecs[v].exp_fcur});
      chk($sformatf("vec%0d_hold_port", v), {24'd0, port_id}, 32'h13);
      chk($sformatf("vec%0d_hold_data", v), {24'd0, out_port}, {28'd0, vecs[v].exp_fcur[27:24]});
    end

    // Reset in the middle of the first dwell, then a clean sweep from a new word.
    f_start = 28'h0BADBAD; f_step = 28'h1; n_points = 16'd3; dwell = 16'd100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_port_id", {24'd0, port_id}, 32'd0);
    chk("mid_rst_out_port", {24'd0, out_port}, 32'd0);
    chk("mid_rst_strobe", {31'd0, write_strobe}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_f_cur", {4'd0, f_cur}, 32'd0);
    run_sweep(28'h0C0FFEE, 28'h0000010, 16'd2, 16'd81, -1, -1, ns, nd);
    chk("post_rst_strobes", 32'(ns), 32'd8);
    chk("post_rst_done", 32'(nd), 32'd1);

    for (int r = 0; r < 6; r++) begin
      logic [27:0] rfs, rst_v;
      logic [15:0] rnp, rdw;
      int npe, d, per, p, a, m, done_c;
      rfs   = 28'($urandom);
      rst_v = 28'($urandom);
      rnp   = 16'($urandom_range(0, 3));
      rdw   = 16'($urandom_range(0, 120));
      npe   = (rnp == 16'd0) ? 1 : int'(rnp);
      d     = (rdw < 16'd80) ? 80 : int'(rdw);
      per   = 6 + d;
      done_c = 2 + (npe - 1) * per + 6 + d;
      a = -1;
      m = -1;
      if ($urandom_range(0, 1) == 1) begin
        p = $urandom_range(0, npe - 1);
        if ($urandom_range(0, 1) == 1) a = 2 + p * per + $urandom_range(0, 5);
        else a = 2 + p * per + 6 + $urandom_range(0, d - 2);
        if ($urandom_range(0, 1) == 1) m = $urandom_range(1, a);
      end else if ($urandom_range(0, 1) == 1) begin
        m = $urandom_range(1, done_c - 1);
      end
      run_sweep(rfs, rst_v, rnp, rdw, a, m, ns, nd);
      chk($sformatf("rnd%0d_done", r), 32'(nd), (a < 0) ? 32'd1 : 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
